// File: rtl/spart_pkg.sv
// Shared SPART bus definitions: register addresses, status bits, driver states
// and the baud divisor computation.
package spart_pkg;

  localparam logic [1:0] ADDR_DATA = 2'b00;
  localparam logic [1:0] ADDR_STAT = 2'b01;
  localparam logic [1:0] ADDR_DBL  = 2'b10;
  localparam logic [1:0] ADDR_DBH  = 2'b11;

  localparam int unsigned STAT_RDA = 0;
  localparam int unsigned STAT_TBR = 1;

  typedef enum logic [2:0] {
    CFG_LO,
    CFG_HI,
    POLL,
    RD_RX,
    WR_TX
  } state_t;

  // Baud is 4800 << br_cfg; divisor = CLK_HZ/(16*baud) - 1, truncated.
  function automatic logic [15:0] divisor(input logic [1:0] br_cfg,
                                          input int unsigned clk_hz);
    int unsigned baud;
    int unsigned q;
    baud = 32'd4800 << br_cfg;
    q    = clk_hz / (32'd16 * baud) - 32'd1;
    return q[15:0];
  endfunction

endpackage

// File: rtl/spart_driver.sv
// SPART bus initiator: programs the baud divisor from br_cfg, then polls status
// and echoes each received byte back to the transmit buffer.
module spart_driver
  import spart_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] br_cfg,
  output logic       iocs,
  output logic       iorw,
  output logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  output logic       rx_strobe,
  output logic [7:0] rx_byte,
  output logic [7:0] echo_count,
  output logic       cfg_done
);

  state_t      state, state_next;
  logic [7:0]  hold;
  logic        full;
  logic [1:0]  cfg_q;
  logic [15:0] div;
  logic        bus_cs, bus_rw;
  logic [1:0]  bus_addr;
  logic [7:0]  wdata;

  always_comb begin
    case (br_cfg)
      2'b00:   div = divisor(2'b00, CLK_HZ);
      2'b01:   div = divisor(2'b01, CLK_HZ);
      2'b10:   div = divisor(2'b10, CLK_HZ);
      default: div = divisor(2'b11, CLK_HZ);
    endcase
  end

  // Bus access is a pure decode of the state register, so each state's access
  // lands in the cycle the FSM occupies that state.
  always_comb begin
    bus_cs   = 1'b1;
    bus_rw   = 1'b1;
    bus_addr = ADDR_STAT;
    wdata    = hold;
    case (state)
      CFG_LO: begin
        bus_rw   = 1'b0;
        bus_addr = ADDR_DBL;
        wdata    = div[7:0];
      end
      CFG_HI: begin
        bus_rw   = 1'b0;
        bus_addr = ADDR_DBH;
        wdata    = div[15:8];
      end
      POLL:  bus_addr = ADDR_STAT;
      RD_RX: bus_addr = ADDR_DATA;
      WR_TX: begin
        bus_rw   = 1'b0;
        bus_addr = ADDR_DATA;
      end
      default: bus_cs = 1'b0;
    endcase
  end

  // Reset gates the bus so an access in flight is dropped in the same cycle.
  assign iocs    = bus_cs & ~rst;
  assign iorw    = bus_rw | rst;
  assign ioaddr  = rst ? ADDR_DATA : bus_addr;
  assign databus = (iocs && !iorw) ? wdata : 'z;

  always_comb begin
    state_next = state;
    case (state)
      CFG_LO: state_next = CFG_HI;
      CFG_HI: state_next = POLL;
      POLL: begin
        if (br_cfg != cfg_q)                    state_next = CFG_LO;
        else if (full && databus[STAT_TBR])     state_next = WR_TX;
        else if (!full && databus[STAT_RDA])    state_next = RD_RX;
      end
      RD_RX:   state_next = POLL;
      WR_TX:   state_next = POLL;
      default: state_next = CFG_LO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= CFG_LO;
      hold       <= '0;
      full       <= 1'b0;
      cfg_q      <= br_cfg;
      cfg_done   <= 1'b0;
      rx_strobe  <= 1'b0;
      rx_byte    <= '0;
      echo_count <= '0;
    end else begin
      state     <= state_next;
      rx_strobe <= (state == RD_RX);
      case (state)
        CFG_HI: begin
          cfg_done <= 1'b1;
          cfg_q    <= br_cfg;
        end
        POLL: if (br_cfg != cfg_q) cfg_done <= 1'b0;
        RD_RX: begin
          hold    <= databus;
          full    <= 1'b1;
          rx_byte <= databus;
        end
        WR_TX: begin
          full       <= 1'b0;
          echo_count <= echo_count + 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
